// File: rtl/hsc_ddr2_burst_arb.sv
// rtl/hsc_ddr2_burst_arb.sv - DDR2 write/read burst arbiter between user FIFOs and the memory controller
// Optional build macro HSC_BURST_RR_EN selects round-robin arbitration instead of write-first priority.
module hsc_ddr2_burst_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  wr_useddw,
    input  logic [9:0]  rd_useddw,
    input  logic [6:0]  wr_rd_burst,
    input  logic [23:0] wr_minaddr,
    input  logic [23:0] wr_maxaddr,
    input  logic [23:0] rd_minaddr,
    input  logic [23:0] rd_maxaddr,
    input  logic        wr_load,
    input  logic        rd_load,
    input  logic        local_init_done,
    input  logic        local_ready,
    input  logic        local_rdata_valid,
    output logic [23:0] local_address,
    output logic        local_write_req,
    output logic        local_read_req,
    output logic        local_burstbegin,
    output logic        wr_fifo_rdreq,
    output logic        rd_fifo_wrreq,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} state_t;

    state_t      state, state_nx;
    logic [23:0] wr_addr, rd_addr;
    logic [6:0]  burst_len, beat_cnt;
    logic        bb_hold;
    logic        wr_load_pend, rd_load_pend;
    logic        wr_elig, rd_elig, start_wr, start_rd;
    logic        wr_done, rd_done, last_beat, in_rd;

    // Wrap test uses 25 bits so an address near the top of the space cannot overflow.
    function automatic logic [23:0] next_addr(input logic [23:0] addr, input logic [23:0] min_addr,
                                              input logic [23:0] max_addr, input logic [6:0] len);
        logic [24:0] adv;
        adv = {1'b0, addr} + {18'b0, len};
        if (adv + {18'b0, len} > {1'b0, max_addr})
            return min_addr;
        return adv[23:0];
    endfunction

    assign wr_elig   = local_init_done && (wr_rd_burst != 7'd0) && (wr_useddw >= {3'b0, wr_rd_burst});
    assign rd_elig   = local_init_done && (wr_rd_burst != 7'd0) && (rd_useddw <  {3'b0, wr_rd_burst});
    assign last_beat = (beat_cnt == burst_len - 7'd1);
    assign in_rd     = (state == READ_CMD) || (state == READ_DATA);
    assign busy      = (state != IDLE);

`ifdef HSC_BURST_RR_EN
    logic last_wr;

    assign start_wr = wr_elig && (!rd_elig || !last_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_wr <= 1'b0;
        else if (state == IDLE && start_wr)
            last_wr <= 1'b1;
        else if (state == IDLE && start_rd)
            last_wr <= 1'b0;
    end
`else
    assign start_wr = wr_elig;
`endif
    assign start_rd = rd_elig && !start_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        local_address    = 24'd0;
        local_write_req  = 1'b0;
        local_read_req   = 1'b0;
        local_burstbegin = 1'b0;
        wr_fifo_rdreq    = 1'b0;
        rd_fifo_wrreq    = 1'b0;
        wr_done          = 1'b0;
        rd_done          = 1'b0;
        case (state)
            IDLE: begin
                if (start_wr)
                    state_nx = WRITE;
                else if (start_rd)
                    state_nx = READ_CMD;
            end
            WRITE: begin
                local_write_req  = 1'b1;
                local_address    = wr_addr;
                local_burstbegin = bb_hold;
                wr_fifo_rdreq    = local_ready;
                if (local_ready && last_beat) begin
                    wr_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            READ_CMD: begin
                local_read_req   = 1'b1;
                local_burstbegin = 1'b1;
                local_address    = rd_addr;
                if (local_ready)
                    state_nx = READ_DATA;
            end
            READ_DATA: begin
                rd_fifo_wrreq = local_rdata_valid;
                if (local_rdata_valid && last_beat) begin
                    rd_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A pending load is applied only outside its own direction's burst, which also
    // gives it precedence over the advance made when that burst completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr      <= wr_minaddr;
            rd_addr      <= rd_minaddr;
            wr_load_pend <= 1'b0;
            rd_load_pend <= 1'b0;
            burst_len    <= 7'd0;
            beat_cnt     <= 7'd0;
            bb_hold      <= 1'b0;
        end else begin
            if (state != WRITE && (wr_load_pend || wr_load)) begin
                wr_addr      <= wr_minaddr;
                wr_load_pend <= 1'b0;
            end else begin
                if (wr_load)
                    wr_load_pend <= 1'b1;
                if (wr_done)
                    wr_addr <= next_addr(wr_addr, wr_minaddr, wr_maxaddr, burst_len);
            end

            if (!in_rd && (rd_load_pend || rd_load)) begin
                rd_addr      <= rd_minaddr;
                rd_load_pend <= 1'b0;
            end else begin
                if (rd_load)
                    rd_load_pend <= 1'b1;
                if (rd_done)
                    rd_addr <= next_addr(rd_addr, rd_minaddr, rd_maxaddr, burst_len);
            end

            case (state)
                IDLE: begin
                    burst_len <= wr_rd_burst;
                    beat_cnt  <= 7'd0;
                    bb_hold   <= 1'b1;
                end
                WRITE: begin
                    if (local_ready) begin
                        beat_cnt <= beat_cnt + 7'd1;
                        bb_hold  <= 1'b0;
                    end
                end
                READ_DATA: begin
                    if (local_rdata_valid)
                        beat_cnt <= beat_cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hsc_ddr2_burst_arb.sv
// tb/tb_hsc_ddr2_burst_arb.sv - self-checking bench for hsc_ddr2_burst_arb against a burst-level model
module tb_hsc_ddr2_burst_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_useddw, rd_useddw;
    logic [6:0]  wr_rd_burst;
    logic [23:0] wr_minaddr, wr_maxaddr, rd_minaddr, rd_maxaddr;
    logic        wr_load, rd_load, local_init_done, local_ready, local_rdata_valid;
    logic [23:0] local_address;
    logic        local_write_req, local_read_req, local_burstbegin;
    logic        wr_fifo_rdreq, rd_fifo_wrreq, busy;

    int checks = 0;
    int errors = 0;

    int m_wr_addr, m_rd_addr;
    bit m_last_wr, m_rd_pend;

    always #5 clk = ~clk;

    hsc_ddr2_burst_arb dut (
        .clk(clk), .rst_n(rst_n),
        .wr_useddw(wr_useddw), .rd_useddw(rd_useddw), .wr_rd_burst(wr_rd_burst),
        .wr_minaddr(wr_minaddr), .wr_maxaddr(wr_maxaddr),
        .rd_minaddr(rd_minaddr), .rd_maxaddr(rd_maxaddr),
        .wr_load(wr_load), .rd_load(rd_load),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_rdata_valid(local_rdata_valid),
        .local_address(local_address), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
        .wr_fifo_rdreq(wr_fifo_rdreq), .rd_fifo_wrreq(rd_fifo_wrreq), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int advance(input int addr, input int mn, input int mx, input int len);
        int n;
        n = addr + len;
        if (n + len > mx)
            return mn;
        return n;
    endfunction

    task automatic model_reset();
        m_wr_addr = int'(wr_minaddr);
        m_rd_addr = int'(rd_minaddr);
        m_last_wr = 1'b0;
        m_rd_pend = 1'b0;
    endtask

    // One decision cycle in IDLE followed by whatever burst the arbitration rules predict.
    // mode: 0 ready/valid always, 1 toggling starting low, 2 random.
    // rload: 0 none, 1 pulse in the decision cycle, 2 pulse mid read-data.
    task automatic burst(input int wfill, input int rfill, input int b, input int mode,
                         input bit wload, input int rload, input bit drop_init, input int reset_at);
        bit we, re, pick_w, pick_r;
        int beats, cyc, strobes, wait_n;
        wr_useddw   = 10'(wfill);
        rd_useddw   = 10'(rfill);
        wr_rd_burst = 7'(b);
        wr_load     = wload;
        rd_load     = (rload == 1);
        we = local_init_done && b != 0 && wfill >= b;
        re = local_init_done && b != 0 && rfill < b;
`ifdef HSC_BURST_RR_EN
        pick_w = we && (!re || !m_last_wr);
`else
        pick_w = we;
`endif
        pick_r = re && !pick_w;
        if (wload)
            m_wr_addr = int'(wr_minaddr);
        if (rload == 1 || m_rd_pend) begin
            m_rd_addr = int'(rd_minaddr);
            m_rd_pend = 1'b0;
        end
        #3;
        chk("idle_busy", busy, 0);
        chk("idle_addr", local_address, 0);
        chk("idle_reqs", {local_write_req, local_read_req, local_burstbegin, wr_fifo_rdreq, rd_fifo_wrreq}, 0);
        tick();
        wr_load = 1'b0;
        rd_load = 1'b0;
        wr_rd_burst = 7'($urandom_range(1, 127));
        if (drop_init)
            local_init_done = 1'b0;
        if (!pick_w && !pick_r) begin
            #3;
            chk("stay_idle", busy, 0);
            return;
        end
        beats = 0;
        cyc = 0;
        strobes = 0;
        if (pick_w) begin
            m_last_wr = 1'b1;
            while (beats < b && cyc < 400) begin
                local_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
                #3;
                chk("wr_req", local_write_req, 1);
                chk("wr_rdreq_low", local_read_req, 0);
                chk("wr_addr", local_address, m_wr_addr);
                chk("wr_bb", local_burstbegin, beats == 0);
                chk("wr_fifo_rdreq", wr_fifo_rdreq, local_ready);
                chk("wr_busy", busy, 1);
                strobes += int'(wr_fifo_rdreq);
                if (cyc == reset_at) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("rst_outputs", {local_write_req, local_read_req, local_burstbegin,
                                        wr_fifo_rdreq, rd_fifo_wrreq, busy}, 0);
                    chk("rst_addr", local_address, 0);
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    local_ready = 1'b0;
                    model_reset();
                    return;
                end
                if (local_ready)
                    beats++;
                cyc++;
                tick();
            end
            chk("wr_strobes", strobes, b);
            m_wr_addr = advance(m_wr_addr, int'(wr_minaddr), int'(wr_maxaddr), b);
        end else begin
            m_last_wr = 1'b0;
            wait_n = (mode == 0) ? 0 : $urandom_range(0, 3);
            for (int k = 0; k <= wait_n; k++) begin
                local_ready = (k == wait_n);
                #3;
                chk("rd_req", local_read_req, 1);
                chk("rd_bb", local_burstbegin, 1);
                chk("rd_addr", local_address, m_rd_addr);
                chk("rd_wrreq_low", local_write_req, 0);
                tick();
            end
            local_ready = 1'b0;
            while (beats < b && cyc < 400) begin
                local_rdata_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
                rd_load = (rload == 2 && cyc == 1);
                #3;
                chk("rdata_wrreq", rd_fifo_wrreq, local_rdata_valid);
                chk("rdata_reqs", {local_read_req, local_write_req, local_burstbegin}, 0);
                chk("rdata_busy", busy, 1);
                strobes += int'(rd_fifo_wrreq);
                if (local_rdata_valid)
                    beats++;
                cyc++;
                tick();
                rd_load = 1'b0;
            end
            local_rdata_valid = 1'b0;
            chk("rd_strobes", strobes, b);
            m_rd_addr = advance(m_rd_addr, int'(rd_minaddr), int'(rd_maxaddr), b);
            if (rload == 2)
                m_rd_pend = 1'b1;
        end
        chk("burst_timeout", cyc < 400, 1);
        #3;
        chk("end_idle", busy, 0);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_useddw = '0; rd_useddw = 10'd1023; wr_rd_burst = 7'd8;
        wr_minaddr = 24'h0; wr_maxaddr = 24'h1000;
        rd_minaddr = 24'h800; rd_maxaddr = 24'h1000;
        wr_load = 1'b0; rd_load = 1'b0;
        local_init_done = 1'b1; local_ready = 1'b0; local_rdata_valid = 1'b0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_addr", local_address, 0);
        chk("reset_reqs", {local_write_req, local_read_req, local_burstbegin, wr_fifo_rdreq, rd_fifo_wrreq}, 0);
        tick();
        rst_n = 1'b1;
        model_reset();

        // single-cycle burstbegin with ready held, address 0 then 8
        burst(8, 1023, 8, 0, 0, 0, 0, -1);
        chk("addr_after_first", m_wr_addr, 8);
        // ready toggling, burstbegin held until first ready
        burst(8, 1023, 8, 1, 0, 0, 0, -1);

        // small window wrap: 0x100, 0x108, 0x100
        wr_minaddr = 24'h100;
        wr_maxaddr = 24'h110;
        burst(8, 1023, 8, 0, 1, 0, 0, -1);
        burst(8, 1023, 8, 2, 0, 0, 0, -1);
        burst(8, 1023, 8, 2, 0, 0, 0, -1);
        chk("wrap_model", m_wr_addr, 24'h108);

        // both directions continuously eligible
        for (int i = 0; i < 4; i++)
            burst(1023, 0, 8, 2, 0, 0, 0, -1);

        // read load mid-data: burst finishes, next read starts at rd_minaddr
        burst(0, 0, 8, 2, 0, 0, 0, -1);
        burst(0, 0, 8, 2, 0, 2, 0, -1);
        chk("rd_pend_model", m_rd_pend, 1);
        burst(0, 0, 8, 0, 0, 0, 0, -1);

        // zero burst length and controller not initialised keep the arbiter idle
        burst(1023, 0, 0, 0, 0, 0, 0, -1);
        burst(40, 1023, 8, 2, 0, 0, 1, -1);
        burst(1023, 0, 8, 0, 0, 0, 0, -1);
        local_init_done = 1'b1;

        // reset in the middle of a write, next write starts at wr_minaddr
        burst(8, 1023, 8, 0, 0, 0, 0, 3);
        burst(8, 1023, 8, 0, 0, 0, 0, -1);

        // randomized traffic
        wr_minaddr = 24'h40;
        wr_maxaddr = 24'h40 + 24'($urandom_range(20, 200));
        rd_minaddr = 24'h3000;
        rd_maxaddr = 24'h3000 + 24'($urandom_range(20, 200));
        burst(0, 1023, 4, 2, 1, 1, 0, -1);
        for (int i = 0; i < 40; i++)
            burst($urandom_range(0, 140), $urandom_range(0, 140), $urandom_range(1, 20), 2,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0) ? 2 : 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
